// File: rtl/io_arb.sv
// io_arb: two-requester round-robin arbiter onto a shared IO register bus.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_req/we/addr/wdata     requester X transfer request (X = 0, 1)
//   mX_gnt                   pulses in the cycle X's transfer is on the slave bus
//   mX_rvalid/rdata          read return for requester X; rdata holds when rvalid is 0
//   s_addr/s_din/s_we        shared slave bus (registered)
//   s_dout                   slave read data, valid one cycle after the address
module io_arb #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_din,
    output logic          s_we,
    input  logic [DW-1:0] s_dout
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    // 1 = m1 was granted last; reset value gives m0 priority
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;

    // Read return pipeline: stage 1 marks a read on the bus last cycle,
    // stage 2 is the registered rvalid capturing the slave's data.
    logic          rd1_v_q;
    logic          rd1_own_q;
    logic          rv0_q, rv1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic elig0, elig1, any_elig, win1;

    always_comb begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = '0;
        din_d   = '0;

        // A requester granted this cycle is excluded, so no back-to-back
        // grant to the same requester is possible.
        elig0    = m0_req && !gnt0_q;
        elig1    = m1_req && !gnt1_q;
        any_elig = elig0 || elig1;
        win1     = elig1 && (!elig0 || !last_q);

        if (any_elig) begin
            state_d = ISSUE;
            gnt0_d  = !win1;
            gnt1_d  = win1;
            last_d  = win1;
            if (win1) begin
                we_d   = m1_we;
                addr_d = m1_addr;
                din_d  = m1_wdata;
            end else begin
                we_d   = m0_we;
                addr_d = m0_addr;
                din_d  = m0_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_v_q   <= 1'b0;
            rd1_own_q <= 1'b0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rd1_v_q   <= (state_q == ISSUE) && !we_q;
            rd1_own_q <= gnt1_q;
            rv0_q     <= rd1_v_q && !rd1_own_q;
            rv1_q     <= rd1_v_q && rd1_own_q;
            if (rd1_v_q && !rd1_own_q) rdata0_q <= s_dout;
            if (rd1_v_q && rd1_own_q)  rdata1_q <= s_dout;
        end
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_din     = din_q;

endmodule

// File: tb/tb_io_arb.sv
module tb_io_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [11:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [11:0] s_addr;
    logic [15:0] s_din;
    logic        s_we;
    logic [15:0] s_dout = '0;

    int n_cmp = 0;
    int n_bad = 0;

    io_arb #(.DW(16), .AW(12)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_din(s_din), .s_we(s_we), .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    // Slave register file model: data = 0x1234 ^ address, one cycle latency
    always @(posedge clk) s_dout <= 16'h1234 ^ {4'h0, s_addr};

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b%b want 00", m0_gnt, m1_gnt); end
        n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
        n_cmp++; if (s_we !== 1'b0 || s_addr !== 12'h000 || s_din !== 16'h0000) begin n_bad++; $display("FAIL rst_bus: we=%b addr=%h din=%h want 0", s_we, s_addr, s_din); end
        n_cmp++; if (m0_rdata !== 16'h0000 || m1_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata: got %h %h want 0", m0_rdata, m1_rdata); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b0 || s_we !== 1'b0) begin n_bad++; $display("FAIL rst_idle: gnt0=%b we=%b want 0", m0_gnt, s_we); end
    endtask

    task automatic test_write();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h001; m0_wdata = 16'hA5A5;
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_bad++; $display("FAIL wr_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
        n_cmp++; if (s_we !== 1'b1 || s_addr !== 12'h001 || s_din !== 16'hA5A5) begin n_bad++; $display("FAIL wr_bus: we=%b addr=%h din=%h want 1 001 a5a5", s_we, s_addr, s_din); end
        m0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_gnt !== 1'b0 || s_we !== 1'b0) begin n_bad++; $display("FAIL wr_after%0d: rv=%b%b gnt0=%b we=%b want 0", i, m0_rvalid, m1_rvalid, m0_gnt, s_we); end
        end
    endtask

    task automatic test_read_m1();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h000;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || s_we !== 1'b0 || s_addr !== 12'h000) begin n_bad++; $display("FAIL rd1_gnt: gnt=%b%b we=%b addr=%h want 01 0 000", m0_gnt, m1_gnt, s_we, s_addr); end
        m1_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd1_early: rvalid=%b want 0", m1_rvalid); end
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h1234) begin n_bad++; $display("FAIL rd1_data: rvalid=%b rdata=%h want 1 1234", m1_rvalid, m1_rdata); end
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd1_other: m0_rvalid=%b want 0", m0_rvalid); end
        @(negedge clk);
    endtask

    // m1 was granted last: both request -> m0 then m1
    task automatic test_priority();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h020;
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || s_addr !== 12'h010) begin n_bad++; $display("FAIL pri_first: gnt=%b%b addr=%h want 10 010", m0_gnt, m1_gnt, s_addr); end
        m0_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || s_addr !== 12'h020) begin n_bad++; $display("FAIL pri_second: gnt=%b%b addr=%h want 01 020", m0_gnt, m1_gnt, s_addr); end
        m1_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 16'h1224) begin n_bad++; $display("FAIL pri_rv0: rv=%b%b rdata=%h want 10 1224", m0_rvalid, m1_rvalid, m0_rdata); end
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 16'h1214) begin n_bad++; $display("FAIL pri_rv1: rv=%b%b rdata=%h want 01 1214", m0_rvalid, m1_rvalid, m1_rdata); end
        @(negedge clk);
        n_cmp++; if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h1224 || m1_rdata !== 16'h1214) begin n_bad++; $display("FAIL pri_hold: rv0=%b rdata=%h %h want 0 1224 1214", m0_rvalid, m0_rdata, m1_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic e_g0, e_g1, e_r0, e_r1;
        logic [11:0] e_addr;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h200;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e_g0   = (k < 6) && (k % 2 == 0);
            e_g1   = (k < 6) && (k % 2 == 1);
            e_addr = e_g0 ? 12'h100 : (e_g1 ? 12'h200 : 12'h000);
            e_r0   = (k >= 2) && (k % 2 == 0);
            e_r1   = (k >= 2) && (k % 2 == 1);
            n_cmp++; if (m0_gnt !== e_g0 || m1_gnt !== e_g1 || s_addr !== e_addr) begin n_bad++; $display("FAIL b2b_gnt%0d: gnt=%b%b addr=%h want %b%b %h", k, m0_gnt, m1_gnt, s_addr, e_g0, e_g1, e_addr); end
            n_cmp++; if (m0_rvalid !== e_r0 || m1_rvalid !== e_r1) begin n_bad++; $display("FAIL b2b_rv%0d: rv=%b%b want %b%b", k, m0_rvalid, m1_rvalid, e_r0, e_r1); end
            if (e_r0) begin
                n_cmp++; if (m0_rdata !== 16'h1334) begin n_bad++; $display("FAIL b2b_rd0_%0d: got %h want 1334", k, m0_rdata); end
            end
            if (e_r1) begin
                n_cmp++; if (m1_rdata !== 16'h1034) begin n_bad++; $display("FAIL b2b_rd1_%0d: got %h want 1034", k, m1_rdata); end
            end
            if (k == 5) begin m0_req = 1'b0; m1_req = 1'b0; end
        end
        @(negedge clk);
    endtask

    task automatic test_hold_m0();
        logic e_g;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h003; m0_wdata = 16'h5555;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e_g = (k % 2 == 0);
            n_cmp++; if (m0_gnt !== e_g || m1_gnt !== 1'b0 || s_we !== e_g) begin n_bad++; $display("FAIL hold_gnt%0d: gnt=%b%b we=%b want %b0 %b", k, m0_gnt, m1_gnt, s_we, e_g, e_g); end
            n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL hold_rv%0d: got %b want 0", k, m0_rvalid); end
        end
        m0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // m0 granted last: both hold reads -> m1, m0, m1; reset hits mid-ISSUE
    task automatic test_reset_mid();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h007;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h00B;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_g1: gnt=%b%b want 01", m0_gnt, m1_gnt); end
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_g2: gnt=%b%b want 10", m0_gnt, m1_gnt); end
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m1_rdata !== 16'h123F || s_addr !== 12'h00B) begin n_bad++; $display("FAIL rm_g3: gnt1=%b rv1=%b rdata=%h addr=%h want 1 1 123f 00b", m1_gnt, m1_rvalid, m1_rdata, s_addr); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_async: gnt=%b%b rv=%b%b want 0000", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid); end
        n_cmp++; if (s_we !== 1'b0 || s_addr !== 12'h000 || m1_rdata !== 16'h0000) begin n_bad++; $display("FAIL rm_bus: we=%b addr=%h rdata1=%h want 0 000 0000", s_we, s_addr, m1_rdata); end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_post%0d: rv=%b%b gnt=%b%b want 0", k, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt); end
        end
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h0AA; m0_wdata = 16'h1111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h0BB; m1_wdata = 16'h2222;
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || s_din !== 16'h1111) begin n_bad++; $display("FAIL rm_sim0: gnt=%b%b din=%h want 10 1111", m0_gnt, m1_gnt, s_din); end
        m0_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || s_din !== 16'h2222 || s_addr !== 12'h0BB) begin n_bad++; $display("FAIL rm_sim1: gnt=%b%b din=%h addr=%h want 01 2222 0bb", m0_gnt, m1_gnt, s_din, s_addr); end
        m1_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_m1();
        test_priority();
        test_back_to_back();
        test_hold_m0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
